// File: rtl/kbd_trainer_pkg.sv
// kbd_trainer_pkg: shared types, defaults and the LFSR helper for the
// typing-trainer checker.
//   state_e      - checker FSM states
//   mode_t       - session mode bits sampled on the start key
//   DEF_*        - default parameter values for kbd_trainer_core
//   lfsr_step()  - one Fibonacci step of x^16+x^14+x^13+x^11+1
package kbd_trainer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_KEY = 2'd1,
    ST_CHECK    = 2'd2,
    ST_ADVANCE  = 2'd3
  } state_e;

  typedef struct packed {
    logic rnd;      // pseudo-random symbol order
    logic adv_err;  // advance to the next symbol even on a mismatch
  } mode_t;

  localparam int unsigned DEF_CODE_W    = 8;
  localparam int unsigned DEF_SEQ_DEPTH = 46;
  localparam int unsigned DEF_CNT_W     = 16;
  localparam int unsigned DEF_IDX_W     = $clog2(DEF_SEQ_DEPTH);
  localparam logic [7:0]  DEF_START_CODE = 8'h5A;

  localparam int unsigned     LFSR_W        = 16;
  localparam logic [LFSR_W-1:0] DEF_LFSR_SEED = 16'hACE1;
  // Feedback taps at bits 15,13,12,10 (x^16, x^14, x^13, x^11)
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 16'hB400;

  // Shift left, XOR of the tapped bits enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/kbd_trainer_if.sv
// kbd_trainer_if: ready/valid scan-code channel from the PS/2 decoder.
//   key_valid  - key_code is valid this cycle (master -> slave)
//   key_code   - scan code (master -> slave)
//   key_ready  - slave accepts; transfer = key_valid & key_ready
interface kbd_trainer_if
  import kbd_trainer_pkg::*;
#(
  parameter int unsigned CODE_W = DEF_CODE_W
) ();

  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;

  modport master (output key_valid, output key_code, input key_ready);
  modport slave  (input key_valid, input key_code, output key_ready);

endinterface

// File: rtl/kbd_seq_rom.sv
// kbd_seq_rom: combinational reference-symbol table, index -> scan code.
//   idx_i  - sequence index
//   code_o - expected scan code; the 46-entry table repeats for deeper
//            sequences
module kbd_seq_rom
  import kbd_trainer_pkg::*;
#(
  parameter int unsigned CODE_W    = DEF_CODE_W,
  parameter int unsigned SEQ_DEPTH = DEF_SEQ_DEPTH,
  parameter int unsigned IDX_W     = $clog2(SEQ_DEPTH)
) (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [CODE_W-1:0] code_o
);

  localparam int unsigned TBL_N = 46;

  // S A G P Q W E R T Y U I O D F H J K L Z X C V B N M ` - = [ ] ; ' , . / 0..9 with 6 last
  localparam logic [7:0] SEQ_TBL [TBL_N] = '{
    8'h1B, 8'h1C, 8'h34, 8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
    8'h3C, 8'h43, 8'h44, 8'h23, 8'h2B, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h1A,
    8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h0E, 8'h4E, 8'h55, 8'h54,
    8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h45, 8'h16, 8'h1E, 8'h26,
    8'h25, 8'h2E, 8'h3D, 8'h3E, 8'h46, 8'h36
  };

  logic [5:0] tbl_a;

  // Table lookup
  always_comb begin
    tbl_a  = 6'(32'(idx_i) % TBL_N);
    code_o = CODE_W'(SEQ_TBL[tbl_a]);
  end

endmodule

// File: rtl/kbd_trainer_core.sv
// kbd_trainer_core: typing-trainer checker. Compares each accepted scan code
// against the current expected symbol and presents that symbol to the VGA
// text layer.
//   clk, reset_signal_n - clock, async active-low reset
//   clear               - synchronous restart to IDLE, highest priority
//   key_if (slave)      - key_valid/key_code in, key_ready out
//   mode_random         - sampled on start: pseudo-random symbol order
//   mode_adv_err        - sampled on start: advance even on mismatch
//   res_out             - last checked key mismatched
//   res_code            - expected code shown on screen
//   hit_cnt, err_cnt    - saturating correct/wrong key counters
//   active              - session running
//   lap_done            - one-cycle pulse after every SEQ_DEPTH hits
module kbd_trainer_core
  import kbd_trainer_pkg::*;
#(
  parameter int unsigned        CODE_W     = DEF_CODE_W,
  parameter int unsigned        SEQ_DEPTH  = DEF_SEQ_DEPTH,
  parameter int unsigned        CNT_W      = DEF_CNT_W,
  parameter logic [CODE_W-1:0]  START_CODE = CODE_W'(DEF_START_CODE),
  parameter logic [LFSR_W-1:0]  LFSR_SEED  = DEF_LFSR_SEED
) (
  input  logic              clk,
  input  logic              reset_signal_n,
  input  logic              clear,
  kbd_trainer_if.slave      key_if,
  input  logic              mode_random,
  input  logic              mode_adv_err,
  output logic              res_out,
  output logic [CODE_W-1:0] res_code,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              active,
  output logic              lap_done
);

  // Candidate index is taken from the low LFSR bits
  localparam int unsigned      IDX_W    = $clog2(SEQ_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_DEPTH - 1);

  state_e state_q, state_d;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  lap_q, lap_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CODE_W-1:0] key_q, key_d;
  logic [CODE_W-1:0] res_code_q, res_code_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic [CNT_W-1:0]  err_q, err_d;
  mode_t             mode_q, mode_d;
  logic              load_q, load_d;
  logic              res_out_q, res_out_d;
  logic              active_q, active_d;
  logic              lap_done_q, lap_done_d;
  logic              key_ready_q, key_ready_d;

  logic              xfer;
  logic              is_start;
  logic              is_null;
  logic              match;
  logic [LFSR_W-1:0] lfsr_nx;
  logic [IDX_W-1:0]  cand;
  logic              cand_ok;
  logic [IDX_W-1:0]  seq_nx_idx;
  logic [IDX_W-1:0]  rom_addr;
  logic [CODE_W-1:0] rom_code;

  // Handshake and comparison decode
  always_comb begin
    xfer       = key_if.key_valid & key_ready_q;
    is_start   = (key_if.key_code == START_CODE);
    is_null    = (key_if.key_code == '0);
    match      = (key_q == res_code_q);
    lfsr_nx    = lfsr_step(lfsr_q);
    cand       = lfsr_nx[IDX_W-1:0];
    // Random search must land on a real entry and move off the current one
    cand_ok    = (32'(cand) < SEQ_DEPTH) && (cand != idx_q);
    // First load after a start shows entry 0 instead of stepping
    seq_nx_idx = load_q ? '0 : ((idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1));
    rom_addr   = mode_q.rnd ? cand : seq_nx_idx;
  end

  kbd_seq_rom #(
    .CODE_W    (CODE_W),
    .SEQ_DEPTH (SEQ_DEPTH),
    .IDX_W     (IDX_W)
  ) u_rom (
    .idx_i  (rom_addr),
    .code_o (rom_code)
  );

  // State register
  always_ff @(posedge clk or negedge reset_signal_n) begin
    if (!reset_signal_n) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer && is_start) state_d = ST_ADVANCE;
        end
        ST_WAIT_KEY: begin
          if (xfer && is_start)     state_d = ST_ADVANCE;
          else if (xfer && !is_null) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (match || mode_q.adv_err) state_d = ST_ADVANCE;
          else                         state_d = ST_WAIT_KEY;
        end
        ST_ADVANCE: begin
          if (!mode_q.rnd || cand_ok) state_d = ST_WAIT_KEY;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    idx_d       = idx_q;
    lap_d       = lap_q;
    lfsr_d      = lfsr_q;
    key_d       = key_q;
    res_code_d  = res_code_q;
    hit_d       = hit_q;
    err_d       = err_q;
    mode_d      = mode_q;
    load_d      = load_q;
    res_out_d   = res_out_q;
    active_d    = active_q;
    lap_done_d  = 1'b0;
    // Registered so key_ready is a flop output reflecting the coming state
    key_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_KEY);

    if (clear) begin
      idx_d      = '0;
      lap_d      = '0;
      lfsr_d     = LFSR_SEED;
      key_d      = '0;
      res_code_d = START_CODE;
      hit_d      = '0;
      err_d      = '0;
      mode_d     = '0;
      load_d     = 1'b0;
      res_out_d  = 1'b0;
      active_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_WAIT_KEY: begin
          if (xfer && is_start) begin
            mode_d.rnd     = mode_random;
            mode_d.adv_err = mode_adv_err;
            hit_d          = '0;
            err_d          = '0;
            lap_d          = '0;
            idx_d          = '0;
            active_d       = 1'b1;
            load_d         = 1'b1;
          end else if (xfer && !is_null && (state_q == ST_WAIT_KEY)) begin
            key_d = key_if.key_code;
          end
        end
        ST_CHECK: begin
          if (match) begin
            res_out_d = 1'b0;
            if (hit_q != '1) hit_d = hit_q + CNT_W'(1);
            if (lap_q == LAST_IDX) begin
              lap_d      = '0;
              lap_done_d = 1'b1;
            end else begin
              lap_d = lap_q + IDX_W'(1);
            end
          end else begin
            res_out_d = 1'b1;
            if (err_q != '1) err_d = err_q + CNT_W'(1);
          end
        end
        ST_ADVANCE: begin
          if (mode_q.rnd) begin
            lfsr_d = lfsr_nx;
            if (cand_ok) begin
              idx_d      = cand;
              res_code_d = rom_code;
              load_d     = 1'b0;
            end
          end else begin
            idx_d      = seq_nx_idx;
            res_code_d = rom_code;
            load_d     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_signal_n) begin
    if (!reset_signal_n) begin
      idx_q       <= '0;
      lap_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      key_q       <= '0;
      res_code_q  <= START_CODE;
      hit_q       <= '0;
      err_q       <= '0;
      mode_q      <= '0;
      load_q      <= 1'b0;
      res_out_q   <= 1'b0;
      active_q    <= 1'b0;
      lap_done_q  <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      idx_q       <= idx_d;
      lap_q       <= lap_d;
      lfsr_q      <= lfsr_d;
      key_q       <= key_d;
      res_code_q  <= res_code_d;
      hit_q       <= hit_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      load_q      <= load_d;
      res_out_q   <= res_out_d;
      active_q    <= active_d;
      lap_done_q  <= lap_done_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign key_if.key_ready = key_ready_q;
  assign res_out          = res_out_q;
  assign res_code         = res_code_q;
  assign hit_cnt          = hit_q;
  assign err_cnt          = err_q;
  assign active           = active_q;
  assign lap_done         = lap_done_q;

endmodule

// File: tb/tb_kbd_trainer_core.sv
// tb_kbd_trainer_core: randomized self-checking bench. Two checkers run in
// lockstep on identical stimulus, one with 16-bit and one with 4-bit counters,
// against a behavioural model of the session rules.
module tb_kbd_trainer_core;

  localparam int unsigned DEPTH = 46;
  localparam logic [7:0]  START = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear, mode_random, mode_adv_err;

  kbd_trainer_if #(.CODE_W(8)) kif  ();
  kbd_trainer_if #(.CODE_W(8)) kif4 ();

  logic        res_out_a, active_a, lap_a;
  logic [7:0]  res_code_a;
  logic [15:0] hit_a, err_a;
  logic        res_out_b, active_b, lap_b;
  logic [7:0]  res_code_b;
  logic [3:0]  hit_b, err_b;

  kbd_trainer_core dut (
    .clk(clk), .reset_signal_n(rst_n), .clear(clear), .key_if(kif.slave),
    .mode_random(mode_random), .mode_adv_err(mode_adv_err),
    .res_out(res_out_a), .res_code(res_code_a), .hit_cnt(hit_a), .err_cnt(err_a),
    .active(active_a), .lap_done(lap_a)
  );

  kbd_trainer_core #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_signal_n(rst_n), .clear(clear), .key_if(kif4.slave),
    .mode_random(mode_random), .mode_adv_err(mode_adv_err),
    .res_out(res_out_b), .res_code(res_code_b), .hit_cnt(hit_b), .err_cnt(err_b),
    .active(active_b), .lap_done(lap_b)
  );

  logic [7:0] ref_rom [DEPTH] = '{
    8'h1B, 8'h1C, 8'h34, 8'h4D, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
    8'h3C, 8'h43, 8'h44, 8'h23, 8'h2B, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h1A,
    8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h0E, 8'h4E, 8'h55, 8'h54,
    8'h5B, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A, 8'h45, 8'h16, 8'h1E, 8'h26,
    8'h25, 8'h2E, 8'h3D, 8'h3E, 8'h46, 8'h36
  };

  int n_checks = 0;
  int n_errors = 0;

  // lap_done pulses seen on each instance
  int laps_a = 0;
  int laps_b = 0;
  always @(negedge clk) begin
    if (lap_a) laps_a++;
    if (lap_b) laps_b++;
  end

  // Behavioural model of the session
  bit         m_active, m_rnd, m_adv, m_res_out, m_known, m_moved;
  int         m_idx, m_hit, m_err, m_lap, m_laps;
  logic [7:0] m_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit in_rom(input logic [7:0] c);
    for (int i = 0; i < int'(DEPTH); i++) if (ref_rom[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] wrong_code(input logic [7:0] exp);
    logic [7:0] c;
    do c = 8'($urandom); while (c == exp || c == 8'h00 || c == START);
    return c;
  endfunction

  task automatic drive(input logic v, input logic [7:0] c);
    kif.key_valid  = v;
    kif.key_code   = c;
    kif4.key_valid = v;
    kif4.key_code  = c;
  endtask

  task automatic model_reset();
    m_active = 0; m_rnd = 0; m_adv = 0; m_res_out = 0; m_known = 1; m_moved = 0;
    m_idx = 0; m_hit = 0; m_err = 0; m_lap = 0;
    m_exp = START;
  endtask

  task automatic model_advance();
    m_moved = 1;
    if (m_rnd) m_known = 0;
    else begin
      m_idx = (m_idx + 1) % int'(DEPTH);
      m_exp = ref_rom[m_idx];
    end
  endtask

  // Applies one accepted key; returns expected key_ready-low cycles
  task automatic model_key(input logic [7:0] code, output int busy, output bit at_least);
    busy = 0; at_least = 0; m_moved = 0;
    if (code == START) begin
      m_active = 1; m_rnd = mode_random; m_adv = mode_adv_err;
      m_hit = 0; m_err = 0; m_lap = 0; m_idx = 0;
      busy = 1; at_least = m_rnd;
      if (m_rnd) m_known = 0;
      else begin m_exp = ref_rom[0]; m_known = 1; end
    end else if (m_active && code != 8'h00) begin
      if (code == m_exp) begin
        m_hit++; m_res_out = 0; m_lap++;
        if (m_lap == int'(DEPTH)) begin m_lap = 0; m_laps++; end
        model_advance();
        busy = 2; at_least = m_rnd;
      end else begin
        m_err++; m_res_out = 1;
        if (m_adv) begin model_advance(); busy = 2; at_least = m_rnd; end
        else busy = 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".res_out"},   32'(res_out_a),  32'(m_res_out));
    check_eq({tag, ".res_out4"},  32'(res_out_b),  32'(m_res_out));
    check_eq({tag, ".res_code"},  32'(res_code_a), 32'(m_exp));
    check_eq({tag, ".res_code4"}, 32'(res_code_b), 32'(m_exp));
    check_eq({tag, ".active"},    32'(active_a),   32'(m_active));
    check_eq({tag, ".active4"},   32'(active_b),   32'(m_active));
    check_eq({tag, ".hit"},       32'(hit_a),      32'(sat(m_hit, 16)));
    check_eq({tag, ".hit4"},      32'(hit_b),      32'(sat(m_hit, 4)));
    check_eq({tag, ".err"},       32'(err_a),      32'(sat(m_err, 16)));
    check_eq({tag, ".err4"},      32'(err_b),      32'(sat(m_err, 4)));
    check_eq({tag, ".laps"},      32'(laps_a),     32'(m_laps));
    check_eq({tag, ".laps4"},     32'(laps_b),     32'(m_laps));
    check_eq({tag, ".ready"},     32'(kif.key_ready), 32'd1);
  endtask

  // Offers one key, optionally spraying junk while key_ready is low, then checks
  task automatic send_key(input string tag, input logic [7:0] code, input bit junk);
    int busy, lowc, n;
    bit at_least;
    logic [7:0] prev;
    n = 0;
    while (!kif.key_ready && n < 300) begin @(negedge clk); n++; end
    check_eq({tag, ".ready_wait"}, 32'(kif.key_ready), 32'd1);
    prev = res_code_a;
    model_key(code, busy, at_least);
    drive(1'b1, code);
    @(negedge clk);
    drive(1'b0, 8'h00);
    lowc = 0;
    while (!kif.key_ready && lowc < 300) begin
      drive(junk, 8'($urandom));
      @(negedge clk);
      lowc++;
    end
    drive(1'b0, 8'h00);
    if (at_least) check_eq({tag, ".busy_min"}, 32'(lowc >= busy), 32'd1);
    else          check_eq({tag, ".busy"}, 32'(lowc), 32'(busy));
    if (!m_known) begin
      check_eq({tag, ".in_rom"}, 32'(in_rom(res_code_a)), 32'd1);
      if (m_moved) check_eq({tag, ".new_sym"}, 32'(res_code_a != prev), 32'd1);
      m_exp = res_code_a;
      m_known = 1;
    end
    check_state(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int laps0;
    int busy;
    bit at_least;
    logic [7:0] c;

    rst_n = 1'b0; clear = 1'b0; mode_random = 1'b0; mode_adv_err = 1'b0;
    drive(1'b0, 8'h00);
    model_reset();
    m_laps = 0;
    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Keys before Enter are dropped
    send_key("pre_start", 8'h1B, 1'b0);
    send_key("start", START, 1'b0);

    // Sequential hits
    send_key("seq0", 8'h1B, 1'b0);
    send_key("seq1", 8'h1C, 1'b0);
    send_key("seq2", 8'h34, 1'b0);

    // Hold on mismatch
    send_key("hold_start", START, 1'b0);
    send_key("hold_miss", 8'h1C, 1'b0);
    send_key("hold_hit", 8'h1B, 1'b0);

    // Advance on error, then a full lap of hits
    mode_adv_err = 1'b1;
    send_key("adv_start", START, 1'b0);
    laps0 = laps_a;
    for (int i = 0; i < int'(DEPTH); i++) send_key("adv_miss", wrong_code(m_exp), 1'b1);
    check_eq("adv_no_lap", 32'(laps_a), 32'(laps0));
    for (int i = 0; i < int'(DEPTH); i++) send_key("adv_hit", m_exp, 1'b1);
    check_eq("adv_one_lap", 32'(laps_a), 32'(laps0 + 1));

    // Narrow counters saturate
    mode_adv_err = 1'b0;
    send_key("sat_start", START, 1'b0);
    for (int i = 0; i < 20; i++) send_key("sat_miss", wrong_code(m_exp), 1'b0);
    check_eq("err4_sat", 32'(err_b), 32'hF);

    // Mixed random traffic in sequential order
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 65)      send_key("mix_hit", m_exp, 1'($urandom_range(0, 1)));
      else if (r < 85) send_key("mix_miss", wrong_code(m_exp), 1'($urandom_range(0, 1)));
      else if (r < 93) send_key("mix_null", 8'h00, 1'b0);
      else begin
        mode_adv_err = 1'($urandom_range(0, 1));
        send_key("mix_restart", START, 1'b0);
      end
    end

    // Pseudo-random order with junk offered while busy
    mode_random = 1'b1;
    mode_adv_err = 1'b0;
    send_key("rnd_start", START, 1'b1);
    for (int i = 0; i < 100; i++) send_key("rnd_hit", m_exp, 1'b1);

    // Async reset in the middle of ADVANCE
    mode_random = 1'b0;
    send_key("mid_start", START, 1'b0);
    c = m_exp;
    model_key(c, busy, at_least);
    drive(1'b1, c);
    @(negedge clk);
    drive(1'b0, 8'h00);
    @(posedge clk);
    #1;
    check_eq("mid.in_advance", 32'(kif.key_ready), 32'd0);
    check_eq("mid.hit", 32'(hit_a), 32'(m_hit));
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clear wins over a simultaneous transfer
    send_key("clr_start", START, 1'b0);
    send_key("clr_hit", m_exp, 1'b0);
    c = m_exp;
    clear = 1'b1;
    drive(1'b1, c);
    @(negedge clk);
    clear = 1'b0;
    drive(1'b0, 8'h00);
    model_reset();
    check_state("clear");
    send_key("clr_idle_key", c, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
